// File: rtl/prog_saver.sv
// prog_saver
//   Dumps main memory, starting at address 0, into consecutive MMC blocks
//   through the memory-mapped MMC controller. This is the write-direction
//   counterpart of the boot-time program loader. It drives the shared
//   single-master byte bus only while BUSY is high.
//
// Parameters
//   START_BLOCK   first MMC block written
//   LAST_BLOCK    last MMC block written, inclusive (>= START_BLOCK)
//   POLL_TIMEOUT  status-poll cycles per block before the transfer is aborted
//
// Ports
//   CLK       system clock
//   RST_X     asynchronous active-low reset
//   START     one-cycle request, accepted only while idle
//   DATA_IN   bus read data, sampled two edges after ADDR is registered
//   ADDR      bus address
//   DATA_OUT  bus write data
//   WE        bus write strobe, one byte per high cycle
//   BUSY      transfer in progress
//   DONE      sticky completion flag
//   ERR       sticky status-poll timeout flag

`ifndef ADDR
`define ADDR 24
`endif
`ifndef MMC_START_BLOCK
`define MMC_START_BLOCK 11'd0
`endif
`ifndef MMC_LAST_BLOCK
`define MMC_LAST_BLOCK 11'd0
`endif

module prog_saver #(
    parameter logic [10:0] START_BLOCK  = `MMC_START_BLOCK,
    parameter logic [10:0] LAST_BLOCK   = `MMC_LAST_BLOCK,
    parameter int unsigned POLL_TIMEOUT = 100000000
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             START,
    input  logic [7:0]       DATA_IN,
    output logic [`ADDR-1:0] ADDR,
    output logic [7:0]       DATA_OUT,
    output logic             WE,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [`ADDR-1:0] MMC_CMD  = 24'h800108;
    localparam logic [`ADDR-1:0] MMC_BLK0 = 24'h800109;
    localparam logic [`ADDR-1:0] MMC_BLK1 = 24'h80010a;
    localparam logic [`ADDR-1:0] MMC_BLK2 = 24'h80010b;
    localparam logic [`ADDR-1:0] MMC_BUF  = 24'h800200;
    localparam logic [26:0]      TMO_LIM  = 27'(POLL_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_WR, S_BA0, S_BA1, S_BA2,
        S_CMD, S_SETTLE, S_POLL, S_NEXT
    } state_t;

    state_t           state, state_d;
    logic [10:0]      block, block_d;
    logic [`ADDR-1:0] srcaddr, srcaddr_d;
    logic [8:0]       off, off_d;
    logic [1:0]       cnt, cnt_d;
    logic [26:0]      tmo, tmo_d, tmo_inc;
    logic [`ADDR-1:0] addr_d;
    logic [7:0]       dout_d;
    logic             we_d, busy_d, done_d, err_d;

    assign tmo_inc = tmo + 27'd1;

    // Every output is a register; this process computes all next values.
    // WE defaults low so it is high for exactly one cycle per write state.
    always_comb begin
        state_d   = state;
        block_d   = block;
        srcaddr_d = srcaddr;
        off_d     = off;
        cnt_d     = cnt;
        tmo_d     = tmo;
        addr_d    = ADDR;
        dout_d    = DATA_OUT;
        we_d      = 1'b0;
        busy_d    = BUSY;
        done_d    = DONE;
        err_d     = ERR;
        unique case (state)
            S_IDLE: begin
                if (START) begin
                    block_d   = START_BLOCK;
                    srcaddr_d = '0;
                    off_d     = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_RD0;
                end
            end
            S_RD0: begin
                addr_d  = srcaddr;
                state_d = S_RD1;
            end
            S_RD1: state_d = S_WR;
            S_WR: begin
                // DATA_IN now holds the byte addressed two edges ago in RD0.
                addr_d    = MMC_BUF + {15'd0, off};
                dout_d    = DATA_IN;
                we_d      = 1'b1;
                srcaddr_d = srcaddr + 24'd1;
                off_d     = off + 9'd1;
                state_d   = (off == 9'h1ff) ? S_BA0 : S_RD0;
            end
            S_BA0: begin
                addr_d  = MMC_BLK0;
                dout_d  = {block[6:0], 1'b0};
                we_d    = 1'b1;
                state_d = S_BA1;
            end
            S_BA1: begin
                addr_d  = MMC_BLK1;
                dout_d  = {4'h0, block[10:7]};
                we_d    = 1'b1;
                state_d = S_BA2;
            end
            S_BA2: begin
                addr_d  = MMC_BLK2;
                dout_d  = 8'h00;
                we_d    = 1'b1;
                state_d = S_CMD;
            end
            S_CMD: begin
                addr_d  = MMC_CMD;
                dout_d  = 8'h02;
                we_d    = 1'b1;
                cnt_d   = '0;
                tmo_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // Status read back right after the command is not trusted.
                addr_d  = MMC_CMD;
                cnt_d   = cnt + 2'd1;
                if (cnt == 2'd3) state_d = S_POLL;
            end
            S_POLL: begin
                addr_d = MMC_CMD;
                tmo_d  = tmo_inc;
                // Ready wins over timeout when both land on the same cycle.
                if (DATA_IN == 8'h01) begin
                    state_d = S_NEXT;
                end else if (tmo_inc == TMO_LIM) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_NEXT: begin
                if (block == LAST_BLOCK) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    // srcaddr keeps running so the next block continues the image.
                    block_d = block + 11'd1;
                    off_d   = '0;
                    state_d = S_RD0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state    <= S_IDLE;
            block    <= '0;
            srcaddr  <= '0;
            off      <= '0;
            cnt      <= '0;
            tmo      <= '0;
            ADDR     <= '0;
            DATA_OUT <= '0;
            WE       <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state    <= state_d;
            block    <= block_d;
            srcaddr  <= srcaddr_d;
            off      <= off_d;
            cnt      <= cnt_d;
            tmo      <= tmo_d;
            ADDR     <= addr_d;
            DATA_OUT <= dout_d;
            WE       <= we_d;
            BUSY     <= busy_d;
            DONE     <= done_d;
            ERR      <= err_d;
        end
    end

endmodule

// File: tb/tb_prog_saver.sv
// Bench for prog_saver. Two instances share one bus model style:
//   u_one  blocks 5..5      (single block, memory[a] = a[7:0])
//   u_two  blocks 127..128  (block-address boundary, random data, timeout,
//                            START handling, reset mid-fill)
// The bus model returns memory data one register after ADDR, so the DUT sees
// it on the second edge after ADDR changes; it logs every WE cycle.
`timescale 1ns/1ps
module tb_prog_saver;

    localparam int ND   = 2;
    localparam int LOGN = 8192;

    logic        clk = 1'b0;
    logic        rst_x;
    logic [ND-1:0] start;
    logic [7:0]  din  [ND];
    logic [23:0] addr [ND];
    logic [7:0]  dout [ND];
    logic        we   [ND];
    logic        busy [ND];
    logic        done [ND];
    logic        err  [ND];

    logic [7:0]  mem  [2048];
    logic        stuck[ND];
    logic [23:0] wa   [ND][LOGN];
    logic [7:0]  wd   [ND][LOGN];
    int          wn   [ND];
    int          cmd_cyc[ND];
    int          cyc;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    prog_saver #(.START_BLOCK(11'd5), .LAST_BLOCK(11'd5), .POLL_TIMEOUT(1000)) u_one (
        .CLK(clk), .RST_X(rst_x), .START(start[0]), .DATA_IN(din[0]),
        .ADDR(addr[0]), .DATA_OUT(dout[0]), .WE(we[0]),
        .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0])
    );

    prog_saver #(.START_BLOCK(11'd127), .LAST_BLOCK(11'd128), .POLL_TIMEOUT(1000)) u_two (
        .CLK(clk), .RST_X(rst_x), .START(start[1]), .DATA_IN(din[1]),
        .ADDR(addr[1]), .DATA_OUT(dout[1]), .WE(we[1]),
        .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1])
    );

    // Bus model: write log, memory reads, MMC status (ready 10 cycles after command).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < ND; d++) begin
            if (we[d]) begin
                if (wn[d] < LOGN) begin
                    wa[d][wn[d]] <= addr[d];
                    wd[d][wn[d]] <= dout[d];
                end
                wn[d] <= wn[d] + 1;
                if (addr[d] == 24'h800108) cmd_cyc[d] <= cyc;
            end
            if (addr[d] == 24'h800108)
                din[d] <= (!stuck[d] && (cyc - cmd_cyc[d] >= 10)) ? 8'h01 : 8'h00;
            else
                din[d] <= mem[addr[d][10:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input int d);
        @(negedge clk); start[d] = 1'b1;
        @(negedge clk); start[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget);
        int k = 0;
        while (busy[d] && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("idle_in_budget%0d", d), 32'(busy[d]), 32'd0);
    endtask

    task automatic check_fill(input int d, input int idx, input int src);
        for (int i = 0; i < 512; i++) begin
            chk($sformatf("fill%0d_addr[%0d]", d, idx + i), 32'(wa[d][idx + i]), 32'h800200 + i);
            chk($sformatf("fill%0d_data[%0d]", d, idx + i), 32'(wd[d][idx + i]), 32'(mem[src + i]));
        end
    endtask

    task automatic check_tail(input int d, input int idx, input logic [7:0] e_lo, input logic [7:0] e_hi);
        chk($sformatf("ba0_addr%0d", d), 32'(wa[d][idx]),     32'h800109);
        chk($sformatf("ba0_data%0d", d), 32'(wd[d][idx]),     32'(e_lo));
        chk($sformatf("ba1_addr%0d", d), 32'(wa[d][idx + 1]), 32'h80010a);
        chk($sformatf("ba1_data%0d", d), 32'(wd[d][idx + 1]), 32'(e_hi));
        chk($sformatf("ba2_addr%0d", d), 32'(wa[d][idx + 2]), 32'h80010b);
        chk($sformatf("ba2_data%0d", d), 32'(wd[d][idx + 2]), 32'h00);
        chk($sformatf("cmd_addr%0d", d), 32'(wa[d][idx + 3]), 32'h800108);
        chk($sformatf("cmd_data%0d", d), 32'(wd[d][idx + 3]), 32'h02);
    endtask

    task automatic check_flags(input string tag, input int d, input logic b, input logic dn, input logic e);
        chk({tag, "_busy"}, 32'(busy[d]), 32'(b));
        chk({tag, "_done"}, 32'(done[d]), 32'(dn));
        chk({tag, "_err"},  32'(err[d]),  32'(e));
    endtask

    // Full two-block run of u_two from srcaddr 0, blocks 127 then 128.
    task automatic run_two(input string tag);
        int base;
        base = wn[1];
        pulse(1);
        check_flags({tag, "_start"}, 1, 1'b1, 1'b0, 1'b0);
        wait_idle(1, 6000);
        chk({tag, "_nwr"}, 32'(wn[1] - base), 32'd1032);
        check_fill(1, base, 0);
        check_tail(1, base + 512, 8'hfe, 8'h00);
        check_fill(1, base + 516, 512);
        check_tail(1, base + 1028, 8'h00, 8'h01);
        check_flags({tag, "_end"}, 1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int base;
        int k;
        rst_x    = 1'b0;
        start    = '0;
        stuck[0] = 1'b0;
        stuck[1] = 1'b0;
        for (int i = 0; i < 2048; i++) mem[i] = i[7:0];

        // Reset values
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_addr%0d", d), 32'(addr[d]), 32'd0);
            chk($sformatf("rst_dout%0d", d), 32'(dout[d]), 32'd0);
            chk($sformatf("rst_we%0d", d),   32'(we[d]),   32'd0);
            check_flags($sformatf("rst%0d", d), d, 1'b0, 1'b0, 1'b0);
        end
        rst_x = 1'b1;
        repeat (2) @(negedge clk);

        // Single block 5: data i, block bytes 0x0a/0x00/0x00
        base = wn[0];
        pulse(0);
        check_flags("one_start", 0, 1'b1, 1'b0, 1'b0);
        wait_idle(0, 4000);
        chk("one_nwr", 32'(wn[0] - base), 32'd516);
        for (int i = 0; i < 512; i++)
            chk($sformatf("one_data[%0d]", i), 32'(wd[0][base + i]), 32'(i[7:0]));
        check_fill(0, base, 0);
        check_tail(0, base + 512, 8'h0a, 8'h00);
        check_flags("one_end", 0, 1'b0, 1'b1, 1'b0);
        chk("one_we_end", 32'(we[0]), 32'd0);

        // Random memory for latency alignment; block boundary 127/128;
        // START pulses while busy must not restart the transfer.
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        base = wn[1];
        pulse(1);
        check_flags("bnd_start", 1, 1'b1, 1'b0, 1'b0);
        repeat (300) @(negedge clk);
        pulse(1);
        chk("mid_start1_busy", 32'(busy[1]), 32'd1);
        repeat (1500) @(negedge clk);
        pulse(1);
        chk("mid_start2_busy", 32'(busy[1]), 32'd1);
        wait_idle(1, 6000);
        chk("bnd_nwr", 32'(wn[1] - base), 32'd1032);
        check_fill(1, base, 0);
        check_tail(1, base + 512, 8'hfe, 8'h00);
        check_fill(1, base + 516, 512);
        check_tail(1, base + 1028, 8'h00, 8'h01);
        check_flags("bnd_end", 1, 1'b0, 1'b1, 1'b0);

        // Poll timeout: status stuck at 0
        stuck[1] = 1'b1;
        base = wn[1];
        pulse(1);
        check_flags("tmo_start", 1, 1'b1, 1'b0, 1'b0);
        k = 0;
        while (!(we[1] && addr[1] == 24'h800108) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_cmd_seen", 32'(we[1] && addr[1] == 24'h800108), 32'd1);
        k = 0;
        while (!err[1] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        // CMD visible -> 4 SETTLE -> 1000 POLL edges
        chk("tmo_cycles", 32'(k), 32'd1004);
        check_flags("tmo_end", 1, 1'b0, 1'b1, 1'b1);
        chk("tmo_nwr", 32'(wn[1] - base), 32'd516);
        k = 0;
        repeat (50) begin
            @(negedge clk);
            if (we[1]) k++;
        end
        chk("tmo_no_we", 32'(k), 32'd0);
        chk("tmo_nwr_after", 32'(wn[1] - base), 32'd516);
        stuck[1] = 1'b0;

        // START after DONE/ERR: flags clear, full sequence repeats from srcaddr 0
        run_two("rerun");

        // Reset during the fill
        base = wn[1];
        pulse(1);
        k = 0;
        while ((wn[1] - base) < 200 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("rstm_reached", 32'(wn[1] - base), 32'd200);
        rst_x = 1'b0;
        #1;
        chk("rstm_addr", 32'(addr[1]), 32'd0);
        chk("rstm_dout", 32'(dout[1]), 32'd0);
        chk("rstm_we",   32'(we[1]),   32'd0);
        check_flags("rstm", 1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_x = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstm_no_writes", 32'(wn[1] - base), 32'd200);
        chk("rstm_idle", 32'(busy[1]), 32'd0);
        run_two("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/prog_saver.md
# prog_saver

Program saver: on a START pulse, copies main memory from address 0 upward into consecutive MMC blocks through the memory-mapped MMC controller. It is the write-direction counterpart of the boot-time program loader. It shares the same single-master byte bus (ADDR/DATA_OUT/WE out, DATA_IN back), so MieruPC2010 can dump a memory image back to the card. It is the bus master only while BUSY=1.

## Interface
- `START_BLOCK`, default `MMC_START_BLOCK`: first MMC block written, 11 bits.
- `LAST_BLOCK`, default `MMC_LAST_BLOCK`: last MMC block written, inclusive; must be ≥ START_BLOCK.
- `POLL_TIMEOUT`, default 100000000: maximum status-poll cycles per block before the block is aborted.
- CLK  in  1  system clock. One clock domain.
- RST_X  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request. Accepted only when BUSY=0.
- DATA_IN  in  8  bus read data. Valid 2 cycles after ADDR is registered.
- ADDR  out  `ADDR (24)  bus address.
- DATA_OUT  out  8  bus write data.
- WE  out  1  bus write strobe. Each cycle with WE=1 is one byte write.
- BUSY  out  1  transfer in progress.
- DONE  out  1  sticky completion flag.
- ERR  out  1  sticky status-poll timeout flag.

## Operation
- Controller register map:
  - 0x800108 is status when read (0x01 = ready) and command when written (0x02 = write buffer to block).
  - 0x800109 = {block[6:0],1'b0}.
  - 0x80010a = {4'h0,block[10:7]}.
  - 0x80010b = 0x00.
  - 0x800200–0x8003ff is the 512-byte block buffer.
- Internal state: `block` (11 b), `srcaddr` (`ADDR`, main-memory read pointer), `off` (9 b, buffer offset), `cnt` (2 b), `tmo` (27 b).
- IDLE: when START=1, load block=START_BLOCK, srcaddr=0, off=0, DONE=0, ERR=0, BUSY=1, then go to RD0.
- RD0: ADDR=srcaddr, WE=0, go to RD1.
- RD1: hold, go to WR.
- WR: ADDR=0x800200+off, DATA_OUT=DATA_IN (sampled at this edge), WE=1; srcaddr++, off++.
  - If off==0x1ff, go to BA0; otherwise go to RD0.
- BA0/BA1/BA2: write the three block-address bytes in order 0x800109, 0x80010a, 0x80010b, WE=1 each.
- CMD: ADDR=0x800108, DATA_OUT=0x02, WE=1; clear cnt and tmo.
- SETTLE: ADDR=0x800108, WE=0 for 4 cycles (cnt 0..3). DATA_IN is ignored during these cycles.
- POLL: ADDR=0x800108, WE=0, tmo++ each cycle.
  - DATA_IN==0x01 → go to NEXT.
  - tmo==POLL_TIMEOUT → ERR=1, DONE=1, BUSY=0, go to IDLE.
- NEXT: WE=0.
  - If block==LAST_BLOCK → DONE=1, BUSY=0, go to IDLE.
  - Otherwise block++, off=0, go to RD0. srcaddr continues and is not reset.
- Arithmetic:
  - Block address bytes are taken from the current `block` value.
  - srcaddr wraps modulo 2^24. The wrap is unreachable with legal parameters.
  - off wraps 0x1ff→0, which is the terminal condition for a block.

## Timing
- Reset values: ADDR=0, DATA_OUT=0, WE=0, BUSY=0, DONE=0, ERR=0, state=IDLE.
- All outputs are registered. BUSY rises on the edge after START is sampled.
- Byte copy takes 3 cycles (RD0, RD1, WR), so a buffer fill is 1536 cycles.
- Per-block overhead: 3 (BA) + 1 (CMD) + 4 (SETTLE) + ≥1 (POLL) + 1 (NEXT) cycles.
- WE is high only in WR, BA0–BA2 and CMD, and for exactly one cycle per byte.
- START while BUSY=1 is ignored. START in the same cycle DONE rises is also ignored.
- DONE and ERR hold until the next accepted START.
- RST_X low at any point, including mid-fill or mid-poll, forces the reset values immediately. No further writes are issued; a partially filled buffer is abandoned.

## Test plan
- Single block:
  - Stimulus: START_BLOCK=LAST_BLOCK=5, memory[a]=a[7:0], status model returns 0x01 10 cycles after command.
  - Required: 512 writes to 0x800200+i with data i[7:0]; then 0x800109←0x0a, 0x80010a←0x00, 0x80010b←0x00, 0x800108←0x02; DONE=1, ERR=0, BUSY=0.
- Block boundary:
  - Stimulus: START_BLOCK=127, LAST_BLOCK=128.
  - Required: first block address bytes 0xfe/0x00/0x00, second block 0x00/0x01/0x00; second buffer filled from srcaddr 0x200–0x3ff.
- Poll timeout:
  - Stimulus: POLL_TIMEOUT=1000, status held at 0x00.
  - Required: ERR=1 and DONE=1 exactly 1000 POLL cycles after SETTLE ends; WE stays 0 afterwards.
- Read latency:
  - Stimulus: memory model with exactly 2-cycle latency and random data.
  - Required: every buffer byte equals memory[srcaddr], with no off-by-one shift.
- START handling:
  - Stimulus: START pulses mid-transfer, then START after DONE.
  - Required: mid-transfer pulses are ignored with no restart; the pulse after DONE clears DONE/ERR and repeats the full sequence.
- Reset mid-operation:
  - Stimulus: RST_X low during byte 200 of the fill.
  - Required: outputs at reset values the same cycle and no WE afterwards; a new START after reset begins at block START_BLOCK, srcaddr 0.
